// File: rtl/bram_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_arbiter_if
//   Bundles every bus signal of the BRAM arbiter: the instruction-fetch port
//   (imem_*), the data port (dmem_*) and the single downstream bram port
//   (bram_*).
//
//   Modports
//     slave  : the arbiter's view. It receives imem/dmem requests and bram
//              responses, and drives imem/dmem completions and bram requests.
//     master : the surrounding system's view (CPU ports plus the bram).
//
//   Signal summary
//     imem_valid/addr          instr request pulse and byte address
//     imem_rdata/ready         instr completion pulse and read data
//     dmem_valid/addr/wdata/wstrb  data request pulse; wstrb==0 means read
//     dmem_rdata/ready         data completion pulse and read data
//     bram_valid/instr/addr/wdata/wstrb  serialised request to bram
//     bram_rdata/ready         bram completion pulse and read data
// ---------------------------------------------------------------------------
interface bram_arbiter_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    logic        bram_valid;
    logic        bram_instr;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata;
    logic        bram_ready;

    modport slave (
        input  imem_valid, imem_addr,
        output imem_rdata, imem_ready,
        input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ready,
        output bram_valid, bram_instr, bram_addr, bram_wdata, bram_wstrb,
        input  bram_rdata, bram_ready
    );

    modport master (
        output imem_valid, imem_addr,
        input  imem_rdata, imem_ready,
        output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ready,
        input  bram_valid, bram_instr, bram_addr, bram_wdata, bram_wstrb,
        output bram_rdata, bram_ready
    );
endinterface

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
//   Merges the instruction-fetch and data ports onto the single bram port.
//   Each port's one-cycle request pulse is captured into a per-port pending
//   slot; slots are then serialised onto bram with exactly one request in
//   flight. bram_instr tags the owner of the in-flight request and the bram
//   completion (ready + rdata) is routed back to that owner only.
//
//   Timing for a request into idle hardware:
//     cycle 0 : *_valid pulse, captured into the slot
//     cycle 1 : IDLE picks the slot and registers it onto bram_*
//     cycle 2 : bram_valid pulse (ISSUE)
//     cycle 3+: WAIT until bram_ready, which is forwarded to the owner port
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous, active-low reset; clears slots, FSM and outputs
//     bus  : bram_arbiter_if.slave, all imem/dmem/bram handshake signals
//
//   Configuration
//     BRAM_ARB_RR_EN : when defined, ties are resolved round-robin (the port
//                      not granted last wins; the history resets to "instr"
//                      so dmem wins the first tie). When undefined, dmem
//                      always wins a tie and imem can starve.
// ---------------------------------------------------------------------------
module bram_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    bram_arbiter_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      state_r;

    // Pending slots, one per port
    logic        islot_v_r;
    logic [31:0] islot_addr_r;
    logic        dslot_v_r;
    logic [31:0] dslot_addr_r;
    logic [31:0] dslot_wdata_r;
    logic [3:0]  dslot_wstrb_r;

    // Registered bram request fields; bram_instr_r doubles as the owner tag
    logic        bram_valid_r;
    logic        bram_instr_r;
    logic [31:0] bram_addr_r;
    logic [31:0] bram_wdata_r;
    logic [3:0]  bram_wstrb_r;

`ifdef BRAM_ARB_RR_EN
    // 1 = the most recent grant went to the instruction port
    logic        last_instr_r;
`endif

    logic        xfer_done_s;
    logic        owner_active_s;
    logic        imem_busy_s;
    logic        dmem_busy_s;
    logic        imem_accept_s;
    logic        dmem_accept_s;
    logic        grant_any_s;
    logic        grant_instr_s;
    logic        imem_ready_s;
    logic        dmem_ready_s;
    logic [31:0] imem_rdata_s;
    logic [31:0] dmem_rdata_s;

`ifdef BRAM_ARB_RR_EN
    // Winner selection: on a tie the port that was not granted last wins.
    function automatic logic pick_instr(input logic i_pend,
                                        input logic d_pend,
                                        input logic last_instr);
        return i_pend & (~d_pend | ~last_instr);
    endfunction
`else
    // Winner selection: dmem has fixed priority over imem.
    function automatic logic pick_instr(input logic i_pend,
                                        input logic d_pend);
        return i_pend & ~d_pend;
    endfunction
`endif

    // Completion routing, per-port busy status, slot acceptance and winner
    always_comb begin
        xfer_done_s    = 1'b0;
        owner_active_s = 1'b0;
        grant_any_s    = 1'b0;
        grant_instr_s  = 1'b0;
        imem_rdata_s   = 32'h0000_0000;
        dmem_rdata_s   = 32'h0000_0000;

        // An owner exists from the grant until the completion cycle.
        owner_active_s = (state_r != ST_IDLE);

        // bram_ready is only meaningful while waiting for a response.
        if (state_r == ST_WAIT) begin
            xfer_done_s = bus.bram_ready;
        end else begin
            xfer_done_s = 1'b0;
        end

        imem_ready_s = xfer_done_s &  bram_instr_r;
        dmem_ready_s = xfer_done_s & ~bram_instr_r;

        if (owner_active_s && bram_instr_r) begin
            imem_rdata_s = bus.bram_rdata;
        end else begin
            imem_rdata_s = 32'h0000_0000;
        end

        if (owner_active_s && !bram_instr_r) begin
            dmem_rdata_s = bus.bram_rdata;
        end else begin
            dmem_rdata_s = 32'h0000_0000;
        end

        // A port is busy while its slot is full or its transfer is in flight;
        // the completion cycle frees it so a new pulse there is accepted.
        imem_busy_s = islot_v_r |
                      (owner_active_s &  bram_instr_r & ~xfer_done_s);
        dmem_busy_s = dslot_v_r |
                      (owner_active_s & ~bram_instr_r & ~xfer_done_s);

        imem_accept_s = bus.imem_valid & ~imem_busy_s;
        dmem_accept_s = bus.dmem_valid & ~dmem_busy_s;

        if ((state_r == ST_IDLE) && (islot_v_r || dslot_v_r)) begin
            grant_any_s = 1'b1;
`ifdef BRAM_ARB_RR_EN
            grant_instr_s = pick_instr(islot_v_r, dslot_v_r, last_instr_r);
`else
            grant_instr_s = pick_instr(islot_v_r, dslot_v_r);
`endif
        end else begin
            grant_any_s   = 1'b0;
            grant_instr_s = 1'b0;
        end
    end

    // Slot capture, request FSM and registered bram request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            islot_v_r     <= 1'b0;
            islot_addr_r  <= 32'h0000_0000;
            dslot_v_r     <= 1'b0;
            dslot_addr_r  <= 32'h0000_0000;
            dslot_wdata_r <= 32'h0000_0000;
            dslot_wstrb_r <= 4'h0;
            bram_valid_r  <= 1'b0;
            bram_instr_r  <= 1'b0;
            bram_addr_r   <= 32'h0000_0000;
            bram_wdata_r  <= 32'h0000_0000;
            bram_wstrb_r  <= 4'h0;
`ifdef BRAM_ARB_RR_EN
            last_instr_r  <= 1'b1;
`endif
        end else begin
            // Instruction slot: accept never coincides with a grant because
            // accept needs an empty slot and a grant needs a full one.
            if (imem_accept_s) begin
                islot_v_r    <= 1'b1;
                islot_addr_r <= bus.imem_addr;
            end else if (grant_any_s && grant_instr_s) begin
                islot_v_r    <= 1'b0;
            end else begin
                islot_v_r    <= islot_v_r;
            end

            // Data slot
            if (dmem_accept_s) begin
                dslot_v_r     <= 1'b1;
                dslot_addr_r  <= bus.dmem_addr;
                dslot_wdata_r <= bus.dmem_wdata;
                dslot_wstrb_r <= bus.dmem_wstrb;
            end else if (grant_any_s && !grant_instr_s) begin
                dslot_v_r     <= 1'b0;
            end else begin
                dslot_v_r     <= dslot_v_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        bram_valid_r <= 1'b1;
                        bram_instr_r <= grant_instr_s;
                        if (grant_instr_s) begin
                            // Instruction fetches are always reads.
                            bram_addr_r  <= islot_addr_r;
                            bram_wdata_r <= 32'h0000_0000;
                            bram_wstrb_r <= 4'h0;
                        end else begin
                            bram_addr_r  <= dslot_addr_r;
                            bram_wdata_r <= dslot_wdata_r;
                            bram_wstrb_r <= dslot_wstrb_r;
                        end
`ifdef BRAM_ARB_RR_EN
                        last_instr_r <= grant_instr_s;
`endif
                        state_r <= ST_ISSUE;
                    end else begin
                        bram_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Single-cycle request pulse; fields stay put for bram.
                    bram_valid_r <= 1'b0;
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    bram_valid_r <= 1'b0;
                    if (bus.bram_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    bram_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bram_valid = bram_valid_r;
    assign bus.bram_instr = bram_instr_r;
    assign bus.bram_addr  = bram_addr_r;
    assign bus.bram_wdata = bram_wdata_r;
    assign bus.bram_wstrb = bram_wstrb_r;
    assign bus.imem_ready = imem_ready_s;
    assign bus.dmem_ready = dmem_ready_s;
    assign bus.imem_rdata = imem_rdata_s;
    assign bus.dmem_rdata = dmem_rdata_s;

endmodule
